// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding, default sizing and select-width helper for the mux scan collector.
package mux_scan_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SETTLE = 1;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_HOLD} state_e;
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
  localparam int DEF_SEL_W = sel_width(DEF_WIDTH);
endpackage

// File: rtl/mux_settle_timer.sv
// mux_settle_timer: loadable down-counter that flags the last settle cycle before a mux sample.
module mux_settle_timer import mux_scan_pkg::*; #(
  parameter int SETTLE = DEF_SETTLE,
  localparam int CW = sel_width(SETTLE + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (load_i) cnt_q <= CW'(SETTLE);
    else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign expired_o = cnt_q == CW'(1);
endmodule

// File: rtl/mux_scan_collector.sv
// mux_scan_collector: steps an 8:1 mux select through every channel and packs the settled samples into a handshaked word.
module mux_scan_collector import mux_scan_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = sel_width(WIDTH),
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  output logic [SEL_W-1:0] sel,
  input  logic             y_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             busy
);
  state_e state_q, entry_st;
  logic [SEL_W-1:0] sel_q;
  logic [WIDTH-1:0] acc_q, acc_d, data_q;
  logic valid_q, hs, last, kill, enter, expired;
  assign kill = abort && state_q != S_IDLE;
  assign hs = valid_q && ready_in;
  assign last = sel_q == SEL_W'(WIDTH - 1);
  assign entry_st = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
  // Every path that (re)starts a channel: fresh scan, next channel, or continuous restart.
  assign enter = !abort && ((state_q == S_IDLE && start) ||
                            (state_q == S_SAMPLE && !last) ||
                            (state_q == S_HOLD && hs && continuous));
  always_comb begin
    acc_d = acc_q;
    acc_d[sel_q] = y_in;
  end
  generate
    if (SETTLE > 0) begin : g_timer
      mux_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (kill),
        .load_i   (enter),
        .dec_i    (state_q == S_SETTLE),
        .expired_o(expired)
      );
    end else begin : g_no_timer
      assign expired = 1'b1;
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q <= '0;
      acc_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else if (kill) begin
      state_q <= S_IDLE;
      sel_q <= '0;
      acc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_SETTLE: if (expired) state_q <= S_SAMPLE;
        S_SAMPLE: begin
          acc_q <= acc_d;
          if (last) begin
            data_q <= acc_d;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: if (hs) begin
          valid_q <= 1'b0;
          if (!continuous) state_q <= S_IDLE;
        end
        default: ;
      endcase
      if (enter) begin
        sel_q <= (state_q == S_SAMPLE) ? sel_q + 1'b1 : '0;
        state_q <= entry_st;
      end
    end
  end
  assign sel = sel_q;
  assign data_out = data_q;
  assign valid_out = valid_q;
  assign busy = state_q != S_IDLE;
endmodule
